// File: rtl/writeback_generator_pkg.sv
// Shared types, widths and RV32I load encodings for the write-back stage.
package writeback_generator_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FUNCT3_W   = 3;
    localparam int unsigned OFF_W      = 2;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned HALF_W     = 16;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // RV32I load funct3 codes; anything not listed behaves as LW.
    typedef enum logic [FUNCT3_W-1:0] {
        FUNCT3_LB  = 3'b000,
        FUNCT3_LH  = 3'b001,
        FUNCT3_LW  = 3'b010,
        FUNCT3_LBU = 3'b100,
        FUNCT3_LHU = 3'b101
    } load_funct3_e;

    // Register-file write presented to the register file and forwarding network.
    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
    } wb_write_t;

    // Extend a byte to the datapath width; sign-extends when is_signed is set.
    function automatic logic [DATA_W-1:0] extend_byte(input logic [BYTE_W-1:0] value,
                                                      input logic              is_signed);
        logic fill;
        fill = is_signed & value[BYTE_W-1];
        return {{(DATA_W-BYTE_W){fill}}, value};
    endfunction

    // Extend a halfword to the datapath width; sign-extends when is_signed is set.
    function automatic logic [DATA_W-1:0] extend_half(input logic [HALF_W-1:0] value,
                                                      input logic              is_signed);
        logic fill;
        fill = is_signed & value[HALF_W-1];
        return {{(DATA_W-HALF_W){fill}}, value};
    endfunction

endpackage

// File: rtl/writeback_generator_load_extender.sv
// Extracts and extends the loaded byte/half/word from an aligned memory word
// and flags addresses that are misaligned for the access width.
module writeback_generator_load_extender
    import writeback_generator_pkg::*;
(
    input  logic [DATA_W-1:0]   mem_r_data,
    input  logic [OFF_W-1:0]    off,
    input  logic [FUNCT3_W-1:0] load_funct3,
    output logic [DATA_W-1:0]   data,
    output logic                misaligned
);

    logic [BYTE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;
    logic [DATA_W-1:0] data_raw;

    // Little-endian byte lane selection.
    always_comb begin
        byte_sel = mem_r_data[BYTE_W-1:0];
        case (off)
            2'd0:    byte_sel = mem_r_data[7:0];
            2'd1:    byte_sel = mem_r_data[15:8];
            2'd2:    byte_sel = mem_r_data[23:16];
            default: byte_sel = mem_r_data[31:24];
        endcase
    end

    // Halfword lane selection; off[0] only matters for alignment.
    always_comb begin
        half_sel = off[1] ? mem_r_data[31:16] : mem_r_data[15:0];
    end

    // Width decode, extension and alignment check.
    always_comb begin
        data_raw   = mem_r_data;
        misaligned = DISABLE;
        case (load_funct3)
            FUNCT3_LB:  data_raw = extend_byte(byte_sel, ENABLE);
            FUNCT3_LBU: data_raw = extend_byte(byte_sel, DISABLE);
            FUNCT3_LH: begin
                data_raw   = extend_half(half_sel, ENABLE);
                misaligned = off[0];
            end
            FUNCT3_LHU: begin
                data_raw   = extend_half(half_sel, DISABLE);
                misaligned = off[0];
            end
            default: begin
                data_raw   = mem_r_data;
                misaligned = (off != 2'd0);
            end
        endcase
    end

    // A misaligned load never produces data.
    always_comb begin
        data = misaligned ? '0 : data_raw;
    end

endmodule

// File: rtl/writeback_generator.sv
// Write-back stage: selects ALU result or extended load data, qualifies the
// register-file write enable and registers the final write.
module writeback_generator
    import writeback_generator_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  is_load,
    input  logic [XLEN-1:0]       mem_r_data,
    input  logic [XLEN-1:0]       alu_result,
    input  logic [FUNCT3_W-1:0]   load_funct3,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  reg_we,
    output logic [XLEN-1:0]       writeback_data,
    output logic                  misaligned,
    output logic [XLEN-1:0]       wb_data_q,
    output logic [REG_ADDR_W-1:0] wb_rd_q,
    output logic                  wb_we_q
);

    logic [DATA_W-1:0] load_data;
    logic              load_misaligned;
    logic              we_eff;
    wb_write_t         wb_d;
    wb_write_t         wb_q;

    writeback_generator_load_extender u_load_extender (
        .mem_r_data  (mem_r_data),
        .off         (alu_result[OFF_W-1:0]),
        .load_funct3 (load_funct3),
        .data        (load_data),
        .misaligned  (load_misaligned)
    );

    // Result select; non-loads pass the ALU result through untouched.
    always_comb begin
        writeback_data = alu_result;
        misaligned     = DISABLE;
        if (is_load == ENABLE) begin
            writeback_data = load_data;
            misaligned     = load_misaligned;
        end
    end

    // Effective enable: drop misaligned loads and any write to x0.
    always_comb begin
        we_eff = reg_we & ~misaligned & (rd_addr != '0);
    end

    // Next write payload; data and rd load every cycle, we_eff qualifies them.
    always_comb begin
        wb_d      = '0;
        wb_d.data = writeback_data;
        wb_d.rd   = rd_addr;
        wb_d.we   = we_eff;
    end

    // Output register; reset drops any in-flight write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    // Registered outputs.
    always_comb begin
        wb_data_q = wb_q.data;
        wb_rd_q   = wb_q.rd;
        wb_we_q   = wb_q.we;
    end

endmodule

// File: tb/tb_writeback_generator.sv
// Scoreboard bench for writeback_generator: driver pushes expected registered
// writes, a monitor pops and compares them after each rising edge.
module tb_writeback_generator;
    import writeback_generator_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_load;
    logic [31:0] mem_r_data;
    logic [31:0] alu_result;
    logic [2:0]  load_funct3;
    logic [4:0]  rd_addr;
    logic        reg_we;
    logic [31:0] writeback_data;
    logic        misaligned;
    logic [31:0] wb_data_q;
    logic [4:0]  wb_rd_q;
    logic        wb_we_q;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    writeback_generator #(.XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .is_load        (is_load),
        .mem_r_data     (mem_r_data),
        .alu_result     (alu_result),
        .load_funct3    (load_funct3),
        .rd_addr        (rd_addr),
        .reg_we         (reg_we),
        .writeback_data (writeback_data),
        .misaligned     (misaligned),
        .wb_data_q      (wb_data_q),
        .wb_rd_q        (wb_rd_q),
        .wb_we_q        (wb_we_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Drive one instruction, check the combinational result, queue the registered one.
    task automatic apply(input string name, input logic ld, input logic [2:0] f3,
                         input logic [31:0] mem, input logic [31:0] alu,
                         input logic [4:0] rd, input logic we,
                         input logic [31:0] exp_wd, input logic exp_mis, input logic exp_we);
        exp_t e;
        @(negedge clk);
        is_load     = ld;
        load_funct3 = f3;
        mem_r_data  = mem;
        alu_result  = alu;
        rd_addr     = rd;
        reg_we      = we;
        #1;
        check({name, "_wd"}, writeback_data, exp_wd);
        check({name, "_mis"}, 32'(misaligned), 32'(exp_mis));
        e.data = exp_wd;
        e.rd   = rd;
        e.we   = exp_we;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the registered write one step after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("reg_data", wb_data_q, e.data);
                check("reg_rd", 32'(wb_rd_q), 32'(e.rd));
                check("reg_we", 32'(wb_we_q), 32'(e.we));
            end
        end
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        rst = 1'b1; is_load = 1'b0; load_funct3 = 3'b000;
        mem_r_data = '0; alu_result = '0; rd_addr = '0; reg_we = 1'b0;
        #3;
        check("rst_data", wb_data_q, 32'h0);
        check("rst_rd", 32'(wb_rd_q), 32'h0);
        check("rst_we", 32'(wb_we_q), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        //     name         ld    f3      mem            alu            rd     we    exp_wd         mis   we_q
        apply("not_load",   1'b0, 3'b010, 32'h0000ffff, 32'h00000a0a, 5'd1,  1'b1, 32'h00000a0a, 1'b0, 1'b1);
        apply("lw",         1'b1, 3'b010, 32'h0000eeee, 32'h0000a0a0, 5'd2,  1'b1, 32'h0000eeee, 1'b0, 1'b1);
        apply("lb_off1",    1'b1, 3'b000, 32'h80f47f12, 32'h00000101, 5'd3,  1'b1, 32'h0000007f, 1'b0, 1'b1);
        apply("lb_off3",    1'b1, 3'b000, 32'h80f47f12, 32'h00000103, 5'd4,  1'b1, 32'hffffff80, 1'b0, 1'b1);
        apply("lbu_off3",   1'b1, 3'b100, 32'h80f47f12, 32'h00000103, 5'd6,  1'b1, 32'h00000080, 1'b0, 1'b1);
        apply("lh_off2",    1'b1, 3'b001, 32'h80f47f12, 32'h00000102, 5'd8,  1'b1, 32'hffff80f4, 1'b0, 1'b1);
        apply("lhu_off2",   1'b1, 3'b101, 32'h80f47f12, 32'h00000102, 5'd9,  1'b1, 32'h000080f4, 1'b0, 1'b1);
        apply("lb_off0",    1'b1, 3'b000, 32'h80f47f12, 32'h00000100, 5'd10, 1'b1, 32'h00000012, 1'b0, 1'b1);
        apply("lhu_off0",   1'b1, 3'b101, 32'h80f47f12, 32'h00000100, 5'd11, 1'b1, 32'h00007f12, 1'b0, 1'b1);
        apply("lw_off2",    1'b1, 3'b010, 32'h80f47f12, 32'h00000102, 5'd5,  1'b1, 32'h00000000, 1'b1, 1'b0);
        apply("lh_off1",    1'b1, 3'b001, 32'h80f47f12, 32'h00000101, 5'd12, 1'b1, 32'h00000000, 1'b1, 1'b0);
        apply("lhu_off3",   1'b1, 3'b101, 32'h80f47f12, 32'h00000103, 5'd13, 1'b1, 32'h00000000, 1'b1, 1'b0);
        apply("f3_011",     1'b1, 3'b011, 32'h13572468, 32'h00000200, 5'd14, 1'b1, 32'h13572468, 1'b0, 1'b1);
        apply("f3_111_off1",1'b1, 3'b111, 32'h13572468, 32'h00000201, 5'd15, 1'b1, 32'h00000000, 1'b1, 1'b0);
        apply("alu_odd",    1'b0, 3'b001, 32'h13572468, 32'hcafe0003, 5'd16, 1'b1, 32'hcafe0003, 1'b0, 1'b1);
        apply("rd_x0",      1'b0, 3'b010, 32'h00000000, 32'h00000055, 5'd0,  1'b1, 32'h00000055, 1'b0, 1'b0);
        apply("no_we",      1'b0, 3'b010, 32'h00000000, 32'h00000077, 5'd4,  1'b0, 32'h00000077, 1'b0, 1'b0);
        apply("rd7",        1'b0, 3'b010, 32'h00000000, 32'h00001234, 5'd7,  1'b1, 32'h00001234, 1'b0, 1'b1);

        // Let the monitor drain, then load a known write without queuing it.
        @(posedge clk); #2;
        @(negedge clk);
        is_load = 1'b0; alu_result = 32'h0000dead; rd_addr = 5'd9; reg_we = 1'b1;
        @(posedge clk); #2;
        check("pre_rst_data", wb_data_q, 32'h0000dead);
        check("pre_rst_we", 32'(wb_we_q), 32'h1);

        // Asynchronous reset between edges.
        #1 rst = 1'b1;
        #1;
        check("arst_data", wb_data_q, 32'h0);
        check("arst_rd", 32'(wb_rd_q), 32'h0);
        check("arst_we", 32'(wb_we_q), 32'h0);
        check("arst_comb", writeback_data, 32'h0000dead);
        alu_result = 32'h0000beef;
        #1;
        check("arst_comb_track", writeback_data, 32'h0000beef);
        @(posedge clk); #1;
        check("arst_hold_data", wb_data_q, 32'h0);
        check("arst_hold_we", 32'(wb_we_q), 32'h0);

        // First edge after release captures the current inputs.
        @(negedge clk);
        rst = 1'b0;
        alu_result = 32'h0000c0de; rd_addr = 5'd11; reg_we = 1'b1;
        #1;
        check("post_rst_comb", writeback_data, 32'h0000c0de);
        e.data = 32'h0000c0de; e.rd = 5'd11; e.we = 1'b1;
        exp_q.push_back(e);

        @(posedge clk); #2;
        @(posedge clk); #2;
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
